// File: rtl/attenuator_scheduler.sv
`timescale 1ns/1ps
// attenuator_scheduler
// Round-robin shares one serial attenuator programming engine among NUM_CH
// requesters. The winner's word is presented on o_tx_data, the start strobe is
// held long enough for the slow serializer clock to see it, and the transfer is
// timed out with a fixed wait because the engine gives no done feedback.
module attenuator_scheduler #(
   parameter int NUM_CH     = 4,
   parameter int DATA_W     = 8,
   parameter int START_HOLD = 80,
   parameter int XFER_WAIT  = 480
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   input  logic [NUM_CH-1:0]        i_req_valid,
   input  logic [NUM_CH*DATA_W-1:0] i_req_data,
   output logic [NUM_CH-1:0]        o_req_ready,
   output logic                     o_tx_start,
   output logic [DATA_W-1:0]        o_tx_data,
   output logic [NUM_CH-1:0]        o_ch_sel,
   output logic                     o_busy,
   output logic [NUM_CH-1:0]        o_done
);

   localparam int PTR_W   = $clog2(NUM_CH);
   localparam int CNT_MAX = (START_HOLD > XFER_WAIT) ? START_HOLD : XFER_WAIT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_HOLD - 1);
   localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(XFER_WAIT - 1);
   localparam logic [PTR_W-1:0] LAST_CH    = PTR_W'(NUM_CH - 1);
   localparam logic [PTR_W:0]   NUM_CH_EXT = (PTR_W+1)'(NUM_CH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_START,
      S_WAIT,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [PTR_W-1:0]    r_ptr;
   logic [PTR_W-1:0]    r_win;
   logic [PTR_W-1:0]    w_pick;
   logic                w_any;
   logic [PTR_W:0]      w_idx;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_tx_data;
   logic [NUM_CH-1:0]   w_win_oh;

   assign w_win_oh  = {{(NUM_CH-1){1'b0}}, 1'b1} << r_win;
   assign o_tx_data = r_tx_data;

   // Round-robin pick: first valid channel at or after the pointer, wrapping.
   always_comb begin
      w_pick = '0;
      w_any  = 1'b0;
      w_idx  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_idx = {1'b0, r_ptr} + (PTR_W+1)'(i);
         if (w_idx >= NUM_CH_EXT) begin
            w_idx = w_idx - NUM_CH_EXT;
         end
         if (!w_any && i_req_valid[w_idx[PTR_W-1:0]]) begin
            w_any  = 1'b1;
            w_pick = w_idx[PTR_W-1:0];
         end
      end
   end

   // State register; reset abandons any transfer in flight.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and state-decoded outputs; everything idles low in S_IDLE.
   always_comb begin
      w_state_nxt = r_state;
      o_req_ready = '0;
      o_tx_start  = 1'b0;
      o_ch_sel    = '0;
      o_busy      = 1'b1;
      o_done      = '0;
      case (r_state)
         S_IDLE: begin
            o_busy = 1'b0;
            if (w_any) begin
               w_state_nxt = S_GRANT;
            end
         end
         S_GRANT: begin
            o_req_ready = w_win_oh;
            o_ch_sel    = w_win_oh;
            w_state_nxt = S_START;
         end
         S_START: begin
            o_tx_start = 1'b1;
            o_ch_sel   = w_win_oh;
            if (r_cnt == '0) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            o_ch_sel = w_win_oh;
            if (r_cnt == '0) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            o_done      = w_win_oh;
            o_ch_sel    = w_win_oh;
            w_state_nxt = S_IDLE;
         end
         default: begin
            o_busy      = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Winner, pointer, phase counter and transmitted word.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_ptr     <= '0;
         r_win     <= '0;
         r_cnt     <= '0;
         r_tx_data <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_win <= w_pick;
               end
            end
            S_GRANT: begin
               r_tx_data <= i_req_data[r_win*DATA_W +: DATA_W];
               r_ptr     <= (r_win == LAST_CH) ? '0 : r_win + 1'b1;
               r_cnt     <= START_LOAD;
            end
            S_START: begin
               r_cnt <= (r_cnt == '0) ? WAIT_LOAD : r_cnt - 1'b1;
            end
            S_WAIT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_attenuator_scheduler.sv
`timescale 1ns/1ps
// Directed bench for attenuator_scheduler: a vector table of single arbitration
// rounds plus hand-written multi-transfer and reset sequences.
module tb_attenuator_scheduler;

   localparam int NUM_CH     = 4;
   localparam int DATA_W     = 8;
   localparam int START_HOLD = 80;
   localparam int XFER_WAIT  = 480;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  valid = '0;
   logic [31:0] data  = '0;

   logic [3:0]  o_req_ready;
   logic        o_tx_start;
   logic [7:0]  o_tx_data;
   logic [3:0]  o_ch_sel;
   logic        o_busy;
   logic [3:0]  o_done;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      string       name;
      logic [3:0]  valid;
      logic [31:0] data;
      logic [3:0]  exp_oh;
      logic [7:0]  exp_w;
   } vec_t;

   vec_t tbl [8];

   attenuator_scheduler #(
      .NUM_CH     (NUM_CH),
      .DATA_W     (DATA_W),
      .START_HOLD (START_HOLD),
      .XFER_WAIT  (XFER_WAIT)
   ) dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_req_valid (valid),
      .i_req_data  (data),
      .o_req_ready (o_req_ready),
      .o_tx_start  (o_tx_start),
      .o_tx_data   (o_tx_data),
      .o_ch_sel    (o_ch_sel),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, " ready"}, 32'(o_req_ready), 32'd0);
      check({name, " start"}, 32'(o_tx_start), 32'd0);
      check({name, " sel"},   32'(o_ch_sel), 32'd0);
      check({name, " busy"},  32'(o_busy), 32'd0);
      check({name, " done"},  32'(o_done), 32'd0);
   endtask

   // Step until a ready pulse appears (bounded); follow() flags a missing one.
   task automatic wait_ready();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (o_req_ready != '0) break;
      end
   endtask

   // Called at the sample where ready is high; walks one whole transfer.
   task automatic follow(input string name, input logic [3:0] exp_oh, input logic [7:0] exp_w,
                         input logic [3:0] clr, input logic [3:0] inj);
      int n;
      int m;
      check({name, " ready"},      32'(o_req_ready), 32'(exp_oh));
      check({name, " sel_grant"},  32'(o_ch_sel), 32'(exp_oh));
      check({name, " busy_grant"}, 32'(o_busy), 32'd1);
      valid = valid & ~clr;
      @(negedge clk);
      n = 0;
      while (o_tx_start === 1'b1 && n < START_HOLD + 5) begin
         if (n == 0) begin
            check({name, " tx_data"},     32'(o_tx_data), 32'(exp_w));
            check({name, " sel_start"},   32'(o_ch_sel), 32'(exp_oh));
            check({name, " ready_pulse"}, 32'(o_req_ready), 32'd0);
         end
         if (n == 10) valid = valid | inj;
         if (n == 11) valid = valid & ~inj;
         n++;
         @(negedge clk);
      end
      check({name, " start_len"}, 32'(n), 32'(START_HOLD));
      m = 0;
      while (o_tx_start === 1'b0 && o_done == '0 && m < XFER_WAIT + 5) begin
         m++;
         @(negedge clk);
      end
      check({name, " wait_len"}, 32'(m), 32'(XFER_WAIT));
      check({name, " done"},     32'(o_done), 32'(exp_oh));
      check({name, " sel_done"}, 32'(o_ch_sel), 32'(exp_oh));
      @(negedge clk);
      check({name, " idle_busy"}, 32'(o_busy), 32'd0);
      check({name, " idle_sel"},  32'(o_ch_sel), 32'd0);
      check({name, " idle_done"}, 32'(o_done), 32'd0);
      check({name, " hold_data"}, 32'(o_tx_data), 32'(exp_w));
   endtask

   logic [3:0] all_oh [4];
   logic [7:0] all_w  [4];
   logic [3:0] rr_oh  [4];
   logic [7:0] rr_w   [4];

   initial begin
      // Pointer state is tracked by hand across entries: 0 on entry to the table.
      tbl[0] = '{"ch2_5a",   4'b0100, 32'h005A_0000, 4'b0100, 8'h5A}; // ptr -> 3
      tbl[1] = '{"wrap_0",   4'b0011, 32'h0000_B2A1, 4'b0001, 8'hA1}; // ptr -> 1
      tbl[2] = '{"skip_3",   4'b1001, 32'hD400_00C3, 4'b1000, 8'hD4}; // ptr -> 0
      tbl[3] = '{"pick_1",   4'b0110, 32'h00F6_E500, 4'b0010, 8'hE5}; // ptr -> 2
      tbl[4] = '{"wrap_1",   4'b0010, 32'h0000_0700, 4'b0010, 8'h07}; // ptr -> 2
      tbl[5] = '{"all_p2",   4'b1111, 32'h4030_2010, 4'b0100, 8'h30}; // ptr -> 3
      tbl[6] = '{"ch3_ff",   4'b1000, 32'hFF00_0000, 4'b1000, 8'hFF}; // ptr -> 0
      tbl[7] = '{"ch0_80",   4'b0001, 32'h0000_0080, 4'b0001, 8'h80}; // ptr -> 1
      all_oh = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      all_w  = '{8'h11, 8'h22, 8'h33, 8'h44};
      rr_oh  = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
      rr_w   = '{8'h77, 8'h99, 8'h77, 8'h99};

      // Reset held: everything low.
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      check("reset tx_data", 32'(o_tx_data), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle_outputs("post_reset");

      // All four request at once: served 0,1,2,3, each leaves after its ready.
      data  = 32'h4433_2211;
      valid = 4'b1111;
      for (int g = 0; g < 4; g++) begin
         wait_ready();
         follow($sformatf("all%0d", g), all_oh[g], all_w[g], all_oh[g], 4'b0000);
      end

      // Ch1 and ch3 hold valid continuously: grants alternate 1,3,1,3.
      data  = 32'h9900_7700;
      valid = 4'b1010;
      for (int g = 0; g < 4; g++) begin
         wait_ready();
         follow($sformatf("rr%0d", g), rr_oh[g], rr_w[g], (g == 3) ? 4'b1111 : 4'b0000, 4'b0000);
      end

      // Table of single arbitration rounds.
      for (int i = 0; i < 8; i++) begin
         valid = tbl[i].valid;
         data  = tbl[i].data;
         wait_ready();
         follow(tbl[i].name, tbl[i].exp_oh, tbl[i].exp_w, 4'b1111, 4'b0000);
      end

      // Ch0 pulses for one cycle while ch2 is being sent: must be ignored.
      valid = 4'b0100;
      data  = 32'h005A_0000;
      wait_ready();
      follow("ignore_ch0", 4'b0100, 8'h5A, 4'b1111, 4'b0001);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("ignore_ch0 no_ready%0d", i), 32'(o_req_ready), 32'd0);
         check($sformatf("ignore_ch0 no_busy%0d", i),  32'(o_busy), 32'd0);
      end

      // Reset in WAIT: outputs drop at once, no done, pointer back to 0.
      valid = 4'b0100;
      data  = 32'h003C_0000;
      wait_ready();
      check("rst_xfer ready", 32'(o_req_ready), 32'(4'b0100));
      valid = 4'b0000;
      repeat (START_HOLD + 100) @(negedge clk);
      check("rst_xfer in_wait_start", 32'(o_tx_start), 32'd0);
      check("rst_xfer in_wait_busy",  32'(o_busy), 32'd1);
      check("rst_xfer in_wait_sel",   32'(o_ch_sel), 32'(4'b0100));
      valid = 4'b1010;
      data  = 32'hAA00_5500;
      #2 rst_n = 1'b0;
      #1;
      check_idle_outputs("async_rst");
      check("async_rst tx_data", 32'(o_tx_data), 32'd0);
      repeat (2) @(negedge clk);
      check_idle_outputs("rst_held");
      rst_n = 1'b1;
      wait_ready();
      follow("rst_ptr", 4'b0010, 8'h55, 4'b1111, 4'b0000);
      valid = 4'b1000;
      wait_ready();
      follow("rst_ch3", 4'b1000, 8'hAA, 4'b1111, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
